arbitro_escrita_registradores: RTL
==================================

Name: arbitro_escrita_registradores

Overview:
- Shares the single write port of banco_registradores between two writeback requesters: A (ALU result) and B (memory load).
- Each requester has a one-entry holding slot with valid/ready handshake.
- A round-robin arbiter with an age rule drains the slots into a registered write stage that drives endereco_regd/data_in/escrita_en of the bank.
- Register 0 is hard-wired: writes to it are accepted and discarded.

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, data width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_a_valid  in  1  requester A has a write
- req_a_ready  out  1  A slot empty; high means accept
- req_a_endereco  in  ADDR_W  A destination register
- req_a_dado  in  DATA_W  A write data
- req_b_valid  in  1  requester B has a write
- req_b_ready  out  1  B slot empty
- req_b_endereco  in  ADDR_W  B destination register
- req_b_dado  in  DATA_W  B write data
- endereco_regd  out  ADDR_W  bank write address (registered)
- data_in  out  DATA_W  bank write data (registered)
- escrita_en  out  1  bank write strobe, one cycle per write (registered)
- ocupado  out  1  any slot occupied or escrita_en high

Behaviour:
- Reset is asynchronous: slots empty, age bit cleared, RR pointer = A, endereco_regd=0, data_in=0, escrita_en=0, ocupado=0, req_x_ready=1 once reset deasserts.
- req_x_ready = !slot_x_occupied, driven combinationally from the slot register only, with no dependence on valid.
- Accept occurs at a rising edge when valid && ready; the slot latches the address and data. Valid while not ready is ignored; the requester must hold its data.
- Arbitration is evaluated each cycle over occupied slots:
  - Only one slot occupied: grant it.
  - Both occupied with different addresses: grant per the RR pointer. After the grant, the pointer moves to the other requester.
  - Both occupied with the same address: grant the older slot. If both were accepted on the same edge, A is older. This preserves write order per register. The RR pointer still toggles.
- At the grant edge, the slot is cleared. If the granted address is nonzero, escrita_en, endereco_regd and data_in load the granted values. If the address is 0, escrita_en=0 and the slot is simply freed.
- When no grant occurs, escrita_en=0. endereco_regd and data_in hold their last values.
- Latency: accept at edge N; the earliest grant is at edge N+1, so escrita_en is high in the cycle after N+1. Refill is possible at edge N+2, giving each requester at most one write per 2 cycles. Combined throughput is one write per cycle.
- Age tracking: a single bit records which slot was filled first. It is updated on accept when the other slot is occupied. It is irrelevant when fewer than 2 slots are occupied.
- Grant and accept on the same edge: a slot cannot be refilled on its own grant edge, because ready is low that cycle. The other slot may accept on that edge.
- Reset asserted mid-operation: pending slots are dropped immediately and escrita_en falls asynchronously.

Optional Feature:
- Macro: ARB_CONTAGEM_CONFLITO_EN.
- When defined:
  - Adds output conflitos [15:0]. It increments at each edge where both slots are occupied, saturates at 16'hFFFF, and resets to 0.
  - Adds output descartes [15:0]. It counts grants to address 0, saturating, and resets to 0.
- When undefined: neither port nor counter exists. Arbitration behaviour is identical.

Test Plan:
- Single A write: req_a (addr 3, data 32'h5) for one cycle → at edge N+1, escrita_en=1 for exactly one cycle with endereco_regd=3, data_in=5; ready_a is low for one cycle.
- Simultaneous different addresses: A (1, 11) and B (2, 22) accepted on the same edge, pointer=A → A written first, B written the next cycle. Repeat → B written first this time (pointer toggled).
- Same-address ordering: A (7, 0xAA) accepted, then B (7, 0xBB) one edge later, pointer=B → A written first, then B; reg 7 ends at 0xBB. Same-edge accept of both → A then B.
- Register 0 discard: B (0, 0xFF) → slot frees, escrita_en stays 0, ready_b returns high after one cycle; with the macro defined, descartes=1.
- Back-to-back streaming: A and B valid every cycle with distinct addresses → escrita_en high every cycle after the first grant, alternating A/B; no write lost or duplicated.
- Async reset mid-flight: assert reset between edges with both slots full → escrita_en=0, ready_a=ready_b=1 after release, no pending write ever issued.

Source files
------------

// File: rtl/arbitro_escrita_registradores_if.sv
// arbitro_escrita_registradores_if: requester handshakes and bank write port of the writeback arbiter.
// With ARB_CONTAGEM_CONFLITO_EN defined it also carries the conflict/discard counters.
interface arbitro_escrita_registradores_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req_a_valid;
    logic              req_a_ready;
    logic [ADDR_W-1:0] req_a_endereco;
    logic [DATA_W-1:0] req_a_dado;
    logic              req_b_valid;
    logic              req_b_ready;
    logic [ADDR_W-1:0] req_b_endereco;
    logic [DATA_W-1:0] req_b_dado;
    logic [ADDR_W-1:0] endereco_regd;
    logic [DATA_W-1:0] data_in;
    logic              escrita_en;
    logic              ocupado;
`ifdef ARB_CONTAGEM_CONFLITO_EN
    logic [15:0]       conflitos;
    logic [15:0]       descartes;
    modport master (
        output req_a_valid, req_a_endereco, req_a_dado,
        output req_b_valid, req_b_endereco, req_b_dado,
        input  req_a_ready, req_b_ready, endereco_regd, data_in, escrita_en, ocupado,
        input  conflitos, descartes
    );
    modport slave (
        input  req_a_valid, req_a_endereco, req_a_dado,
        input  req_b_valid, req_b_endereco, req_b_dado,
        output req_a_ready, req_b_ready, endereco_regd, data_in, escrita_en, ocupado,
        output conflitos, descartes
    );
`else
    modport master (
        output req_a_valid, req_a_endereco, req_a_dado,
        output req_b_valid, req_b_endereco, req_b_dado,
        input  req_a_ready, req_b_ready, endereco_regd, data_in, escrita_en, ocupado
    );
    modport slave (
        input  req_a_valid, req_a_endereco, req_a_dado,
        input  req_b_valid, req_b_endereco, req_b_dado,
        output req_a_ready, req_b_ready, endereco_regd, data_in, escrita_en, ocupado
    );
`endif
endinterface

// File: rtl/arbitro_escrita_registradores.sv
// arbitro_escrita_registradores: two one-entry writeback slots arbitrated round-robin (age rule on same address) into a registered bank write port.
// Optional ARB_CONTAGEM_CONFLITO_EN adds saturating conflitos/descartes counters.
module arbitro_escrita_registradores #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input logic clock,
    input logic reset,
    arbitro_escrita_registradores_if.slave bus
);
    logic              a_v_q, a_v_d, b_v_q, b_v_d;
    logic              age_q, age_d, rr_q, rr_d, en_q, en_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d, wa_q, wa_d;
    logic [DATA_W-1:0] a_data_q, a_data_d, b_data_q, b_data_d, wd_q, wd_d;
    logic              acc_a, acc_b, both, gnt_a, gnt_b, gnt;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
`ifdef ARB_CONTAGEM_CONFLITO_EN
    logic [15:0]       conf_q, conf_d, desc_q, desc_d;
`endif

    always_comb begin
        acc_a    = bus.req_a_valid && !a_v_q;
        acc_b    = bus.req_b_valid && !b_v_q;
        both     = a_v_q && b_v_q;
        // age_q=1 means B is older; only consulted when both slots hold the same register
        gnt_b    = b_v_q && (!a_v_q || ((a_addr_q == b_addr_q) ? age_q : rr_q));
        gnt_a    = a_v_q && !gnt_b;
        gnt      = gnt_a || gnt_b;
        g_addr   = gnt_b ? b_addr_q : a_addr_q;
        g_data   = gnt_b ? b_data_q : a_data_q;
        a_v_d    = acc_a || (a_v_q && !gnt_a);
        b_v_d    = acc_b || (b_v_q && !gnt_b);
        a_addr_d = acc_a ? bus.req_a_endereco : a_addr_q;
        a_data_d = acc_a ? bus.req_a_dado : a_data_q;
        b_addr_d = acc_b ? bus.req_b_endereco : b_addr_q;
        b_data_d = acc_b ? bus.req_b_dado : b_data_q;
        age_d    = (acc_a && acc_b) ? 1'b0 : (acc_a && b_v_q) ? 1'b1 : (acc_b && a_v_q) ? 1'b0 : age_q;
        rr_d     = both ? !rr_q : rr_q;
        en_d     = gnt && (g_addr != '0);
        wa_d     = en_d ? g_addr : wa_q;
        wd_d     = en_d ? g_data : wd_q;
`ifdef ARB_CONTAGEM_CONFLITO_EN
        conf_d   = (both && conf_q != 16'hFFFF) ? conf_q + 16'd1 : conf_q;
        desc_d   = (gnt && g_addr == '0 && desc_q != 16'hFFFF) ? desc_q + 16'd1 : desc_q;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_v_q    <= 1'b0;
            b_v_q    <= 1'b0;
            a_addr_q <= '0;
            a_data_q <= '0;
            b_addr_q <= '0;
            b_data_q <= '0;
            age_q    <= 1'b0;
            rr_q     <= 1'b0;
            en_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
`ifdef ARB_CONTAGEM_CONFLITO_EN
            conf_q   <= '0;
            desc_q   <= '0;
`endif
        end else begin
            a_v_q    <= a_v_d;
            b_v_q    <= b_v_d;
            a_addr_q <= a_addr_d;
            a_data_q <= a_data_d;
            b_addr_q <= b_addr_d;
            b_data_q <= b_data_d;
            age_q    <= age_d;
            rr_q     <= rr_d;
            en_q     <= en_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
`ifdef ARB_CONTAGEM_CONFLITO_EN
            conf_q   <= conf_d;
            desc_q   <= desc_d;
`endif
        end
    end

    assign bus.req_a_ready   = !a_v_q;
    assign bus.req_b_ready   = !b_v_q;
    assign bus.endereco_regd = wa_q;
    assign bus.data_in       = wd_q;
    assign bus.escrita_en    = en_q;
    assign bus.ocupado       = a_v_q || b_v_q || en_q;
`ifdef ARB_CONTAGEM_CONFLITO_EN
    assign bus.conflitos     = conf_q;
    assign bus.descartes     = desc_q;
`endif
endmodule
